sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO, for spy-buffer and pipeline staging paths where both sides share one clock.
- Depth 2^ASIZE; programmable almost-full and almost-empty thresholds.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Exported fill count, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; DEPTH = 2^ASIZE words
ALMOSTFULL, 1, walmostfull asserts when count >= DEPTH-ALMOSTFULL; legal 1..DEPTH-1
ALMOSTEMPTY, 1, ralmostempty asserts when count <= ALMOSTEMPTY; legal 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers, count and sticky flags
wdata  input  DSIZE  write data
winc  input  1  write request
wfull  output  1  count == DEPTH
walmostfull  output  1  count >= DEPTH-ALMOSTFULL
rinc  input  1  read request
rdata  output  DSIZE  read data
rempty  output  1  count == 0
ralmostempty  output  1  count <= ALMOSTEMPTY
count  output  ASIZE+1  words stored, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Storage: DEPTH x DSIZE array. waddr/raddr are ASIZE-bit pointers that wrap modulo DEPTH with no special case. count is a separate ASIZE+1-bit register.
- Write accepted iff winc && !wfull. On accept: mem[waddr] <= wdata, waddr+1.
- Read accepted iff rinc && !rempty. On accept: raddr+1.
- count update per cycle: +1 if write only; -1 if read only; unchanged if both or neither.
- Flags are decoded from the registered count only. There is no combinational path from winc/rinc to any flag.
- Simultaneous winc+rinc:
  - Both accepted when 0 < count < DEPTH.
  - At count == 0: write accepted, read rejected, underflow set. count becomes 1.
  - At count == DEPTH: read accepted, write rejected, overflow set. count becomes DEPTH-1.
- FWFT=0: rdata is a register loaded with mem[raddr] on an accepted read, valid the cycle after rinc (latency 1). It holds its value otherwise, including while empty.
- FWFT=1:
  - rdata = mem[raddr] combinationally whenever rempty=0, i.e. the head word is visible with zero latency.
  - A word written into an empty FIFO appears on rdata the cycle after the write, when rempty falls.
  - rinc pops the head.
  - rdata is don't-care while rempty=1.
- overflow: set on the edge where winc && wfull; underflow: set on the edge where rinc && rempty. Both stay high until flush or reset.
- flush (synchronous, highest priority below reset):
  - Pointers, count, overflow and underflow go to 0.
  - winc/rinc in that cycle are ignored and do not set the sticky flags.
  - Memory contents are not cleared; FWFT=0 rdata holds its value.
- Reset (rst_n low, asynchronous, any time including mid-burst):
  - Pointers 0, count 0, rempty=1, ralmostempty=1, wfull=0, walmostfull=0, overflow=0, underflow=0, FWFT=0 rdata=0.
  - Release is synchronous to clk. The first write is accepted on the first rising edge after rst_n is high.
- Illegal parameter values (ALMOSTFULL or ALMOSTEMPTY outside the legal range) stop elaboration with a message.

Test Plan:
(All defaults unless stated: DSIZE=8, ASIZE=4, DEPTH=16.)
- Reset state: assert rst_n=0 mid-burst with count=7 -> outputs immediately rempty=1, ralmostempty=1, count=0, wfull=0, overflow=0, underflow=0, rdata=0x00 (FWFT=0).
- Fill/drain: write 0x00..0x0F, then 1 extra write -> after 15 writes walmostfull=1; after 16 wfull=1, count=16; extra write sets overflow=1, count stays 16. Drain 16 reads -> data 0x00..0x0F in order with 1-cycle latency; ralmostempty=1 at count<=1; rempty=1 at 0; a 17th rinc sets underflow=1.
- Wrap and simultaneous access: 40 cycles of winc=rinc=1 starting at count=5 -> count constant at 5, data in order across pointer wrap. winc=rinc=1 at count=0 -> count=1, underflow=1. winc=rinc=1 at count=16 -> count=15, overflow=1.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle rempty=0 and rdata=0xA5 with no rinc; rinc pops it, rempty=1 the following cycle.
- Flush: count=9, overflow=1, winc=1 during flush -> next cycle count=0, rempty=1, overflow=0, no write stored; next write 0x3C is read back first.
- Thresholds ALMOSTFULL=4, ALMOSTEMPTY=3 -> walmostfull rises at count=12; ralmostempty falls at count=4.

Source files
------------

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - write/read/status bundle between a user and sync_fifo_prog
interface sync_fifo_prog_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             flush;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmostfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmostempty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wdata, winc, rinc,
    input  wfull, walmostfull, rdata, rempty, ralmostempty, count, overflow, underflow
  );

  modport slave (
    input  flush, wdata, winc, rinc,
    output wfull, walmostfull, rdata, rempty, ralmostempty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and optional FWFT read
module sync_fifo_prog #(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 4,
  parameter int ALMOSTFULL  = 1,
  parameter int ALMOSTEMPTY = 1,
  parameter int FWFT        = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0]   FULL_LVL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0]   AF_LVL   = (ASIZE+1)'(DEPTH - ALMOSTFULL);
  localparam logic [ASIZE:0]   AE_LVL   = (ASIZE+1)'(ALMOSTEMPTY);
  localparam logic [ASIZE:0]   CNT_ONE  = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] PTR_ONE  = ASIZE'(1);

  if ((ALMOSTFULL < 1) || (ALMOSTFULL > DEPTH - 1)) begin : g_bad_almostfull
    $error("sync_fifo_prog: ALMOSTFULL=%0d outside legal range 1..%0d", ALMOSTFULL, DEPTH - 1);
  end
  if ((ALMOSTEMPTY < 0) || (ALMOSTEMPTY > DEPTH - 1)) begin : g_bad_almostempty
    $error("sync_fifo_prog: ALMOSTEMPTY=%0d outside legal range 0..%0d", ALMOSTEMPTY, DEPTH - 1);
  end

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic [ASIZE-1:0] raddr_q, raddr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_en, rd_en;

  // Status is decoded from the registered count only, so no request input reaches a flag.
  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);
  assign wr_en = bus.winc && !full && !bus.flush;
  assign rd_en = bus.rinc && !empty && !bus.flush;

  assign bus.wfull        = full;
  assign bus.walmostfull  = (count_q >= AF_LVL);
  assign bus.rempty       = empty;
  assign bus.ralmostempty = (count_q <= AE_LVL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Next-state for pointers, occupancy and sticky errors; flush overrides every request.
  always_comb begin
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      waddr_d     = '0;
      raddr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) waddr_d = waddr_q + PTR_ONE;
      if (rd_en) raddr_d = raddr_q + PTR_ONE;
      if (wr_en && !rd_en)      count_d = count_q + CNT_ONE;
      else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
      if (bus.winc && full)  overflow_d  = 1'b1;
      if (bus.rinc && empty) underflow_d = 1'b1;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q     <= '0;
      raddr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive flush and reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr_q] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata = mem_q[raddr_q];
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q, rdata_d;

    // Output register loads the head word only when a read is accepted.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem_q[raddr_q];
    end

    // Registered read data, cleared by reset but not by flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign bus.rdata = rdata_q;
  end
endmodule
